multicycle_controller: RTL and testbench

- Moore-style FSM that sequences the team's next-generation multicycle RV32I datapath. That datapath shares one memory, one ALU and one PC-adder path across cycles.
- Decodes op/func3/func7 from the instruction register and drives every write-enable and mux-select per cycle.
- Uses the ALU flags zero and neg to resolve branches.
- Sits beside the multicycle data path in the top-level CPU, mirroring how the single-cycle controller pairs with its datapath.

---
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I datapath (master) and its
// sequencing controller (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       neg;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [2:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] resultsrc;
    logic       halted;

    modport master (
        output op, func3, func7, zero, neg,
        input  pcwrite, adrsrc, memwrite, irwrite, regwrite, immsrc,
               alusrca, alusrcb, aluop, resultsrc, halted
    );

    modport slave (
        input  op, func3, func7, zero, neg,
        output pcwrite, adrsrc, memwrite, irwrite, regwrite, immsrc,
               alusrca, alusrcb, aluop, resultsrc, halted
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-resource multicycle RV32I datapath.
// Outputs decode from the state register; only BRANCH's pcwrite looks at zero/neg.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          rst,
    multicycle_controller_if.slave        io_bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADR  = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_JALR_JMP = 4'd12,
        S_LUI      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t r_state;
    state_t w_next;

    function automatic logic [2:0] f_aluop(input logic [2:0] f3, input logic sub_sel);
        logic [2:0] res;
        case (f3)
            3'b000:  res = sub_sel ? 3'b001 : 3'b000;
            3'b111:  res = 3'b010;
            3'b110:  res = 3'b011;
            3'b010:  res = 3'b100;
            3'b011:  res = 3'b101;
            3'b100:  res = 3'b110;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic f_alu_f3_ok(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b111, 3'b110, 3'b010, 3'b011, 3'b100: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f_br_f3_ok(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b100, 3'b101: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_HALT;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (io_bus.op)
                    OP_R:     w_next = f_alu_f3_ok(io_bus.func3) ? S_EXEC_R : S_HALT;
                    OP_I:     w_next = f_alu_f3_ok(io_bus.func3) ? S_EXEC_I : S_HALT;
                    OP_LOAD:  w_next = S_MEM_ADR;
                    OP_STORE: w_next = S_MEM_ADR;
                    OP_BR:    w_next = f_br_f3_ok(io_bus.func3) ? S_BRANCH : S_HALT;
                    OP_JAL:   w_next = S_JAL;
                    OP_JALR:  w_next = S_JALR_ADR;
                    OP_LUI:   w_next = S_LUI;
                    default:  w_next = S_HALT;
                endcase
            end
            S_EXEC_R:   w_next = S_ALU_WB;
            S_EXEC_I:   w_next = S_ALU_WB;
            S_ALU_WB:   w_next = S_FETCH;
            S_MEM_ADR:  w_next = (io_bus.op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = S_MEM_WB;
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR:   w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALU_WB;
            S_JALR_ADR: w_next = S_JALR_JMP;
            S_JALR_JMP: w_next = S_ALU_WB;
            S_LUI:      w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_HALT;
        endcase
    end

    // Output decode; reset holds every enable and select low even though state reads FETCH
    always_comb begin
        io_bus.pcwrite   = 1'b0;
        io_bus.adrsrc    = 1'b0;
        io_bus.memwrite  = 1'b0;
        io_bus.irwrite   = 1'b0;
        io_bus.regwrite  = 1'b0;
        io_bus.immsrc    = 3'b000;
        io_bus.alusrca   = 2'b00;
        io_bus.alusrcb   = 2'b00;
        io_bus.aluop     = 3'b000;
        io_bus.resultsrc = 2'b00;
        io_bus.halted    = 1'b0;
        if (rst) begin
            io_bus.pcwrite = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    io_bus.irwrite   = 1'b1;
                    io_bus.alusrcb   = 2'b10;
                    io_bus.resultsrc = 2'b10;
                    io_bus.pcwrite   = 1'b1;
                end
                S_DECODE: begin
                    io_bus.alusrca = 2'b01;
                    io_bus.alusrcb = 2'b01;
                    io_bus.immsrc  = 3'b010;
                end
                S_EXEC_R: begin
                    io_bus.alusrca = 2'b10;
                    io_bus.aluop   = f_aluop(io_bus.func3, io_bus.func7[5]);
                end
                S_EXEC_I: begin
                    io_bus.alusrca = 2'b10;
                    io_bus.alusrcb = 2'b01;
                    io_bus.aluop   = f_aluop(io_bus.func3, 1'b0);
                end
                S_ALU_WB: io_bus.regwrite = 1'b1;
                S_MEM_ADR: begin
                    io_bus.alusrca = 2'b10;
                    io_bus.alusrcb = 2'b01;
                    io_bus.immsrc  = (io_bus.op == OP_LOAD) ? 3'b000 : 3'b001;
                end
                S_MEM_RD: io_bus.adrsrc = 1'b1;
                S_MEM_WB: begin
                    io_bus.regwrite  = 1'b1;
                    io_bus.resultsrc = 2'b01;
                end
                S_MEM_WR: begin
                    io_bus.adrsrc   = 1'b1;
                    io_bus.memwrite = 1'b1;
                end
                S_BRANCH: begin
                    io_bus.alusrca = 2'b10;
                    io_bus.aluop   = 3'b001;
                    case (io_bus.func3)
                        3'b000:  io_bus.pcwrite = io_bus.zero;
                        3'b001:  io_bus.pcwrite = ~io_bus.zero;
                        3'b100:  io_bus.pcwrite = io_bus.neg;
                        3'b101:  io_bus.pcwrite = ~io_bus.neg;
                        default: io_bus.pcwrite = 1'b0;
                    endcase
                end
                S_JAL, S_JALR_JMP: begin
                    io_bus.alusrca = 2'b01;
                    io_bus.alusrcb = 2'b10;
                    io_bus.pcwrite = 1'b1;
                end
                S_JALR_ADR: begin
                    io_bus.alusrca = 2'b10;
                    io_bus.alusrcb = 2'b01;
                end
                S_LUI: begin
                    io_bus.immsrc    = 3'b011;
                    io_bus.resultsrc = 2'b11;
                    io_bus.regwrite  = 1'b1;
                end
                S_HALT:  io_bus.halted = 1'b1;
                default: io_bus.halted = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: walks each instruction class through the controller and checks
// the full control word every cycle against hand-built expected vectors.
module tb_multicycle_controller;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    multicycle_controller_if ifc ();

    multicycle_controller dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcwrite, adrsrc, memwrite, irwrite, regwrite, immsrc, alusrca, alusrcb, aluop, resultsrc, halted}
    logic [17:0] w_obs;
    assign w_obs = {ifc.pcwrite, ifc.adrsrc, ifc.memwrite, ifc.irwrite, ifc.regwrite,
                    ifc.immsrc, ifc.alusrca, ifc.alusrcb, ifc.aluop, ifc.resultsrc, ifc.halted};

    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [2:0] imm,
                                       input logic [1:0] asa, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic [1:0] rs,
                                       input logic h);
        return {pcw, adr, mw, irw, rw, imm, asa, asb, aop, rs, h};
    endfunction

    logic [17:0] e_zero, e_fetch, e_decode, e_add, e_sub, e_xori, e_alu_wb;
    logic [17:0] e_adr_ld, e_adr_st, e_mem_rd, e_mem_wb, e_mem_wr;
    logic [17:0] e_br_t, e_br_n, e_jal, e_jalr_adr, e_jalr_jmp, e_lui, e_halt;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [17:0] exp);
        check(tag, w_obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic n);
        ifc.op    = op;
        ifc.func3 = f3;
        ifc.func7 = f7;
        ifc.zero  = z;
        ifc.neg   = n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs", w_obs, e_zero);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        e_zero     = mk(0,0,0,0,0,3'b000,2'b00,2'b00,3'b000,2'b00,0);
        e_fetch    = mk(1,0,0,1,0,3'b000,2'b00,2'b10,3'b000,2'b10,0);
        e_decode   = mk(0,0,0,0,0,3'b010,2'b01,2'b01,3'b000,2'b00,0);
        e_add      = mk(0,0,0,0,0,3'b000,2'b10,2'b00,3'b000,2'b00,0);
        e_sub      = mk(0,0,0,0,0,3'b000,2'b10,2'b00,3'b001,2'b00,0);
        e_xori     = mk(0,0,0,0,0,3'b000,2'b10,2'b01,3'b110,2'b00,0);
        e_alu_wb   = mk(0,0,0,0,1,3'b000,2'b00,2'b00,3'b000,2'b00,0);
        e_adr_ld   = mk(0,0,0,0,0,3'b000,2'b10,2'b01,3'b000,2'b00,0);
        e_adr_st   = mk(0,0,0,0,0,3'b001,2'b10,2'b01,3'b000,2'b00,0);
        e_mem_rd   = mk(0,1,0,0,0,3'b000,2'b00,2'b00,3'b000,2'b00,0);
        e_mem_wb   = mk(0,0,0,0,1,3'b000,2'b00,2'b00,3'b000,2'b01,0);
        e_mem_wr   = mk(0,1,1,0,0,3'b000,2'b00,2'b00,3'b000,2'b00,0);
        e_br_t     = mk(1,0,0,0,0,3'b000,2'b10,2'b00,3'b001,2'b00,0);
        e_br_n     = mk(0,0,0,0,0,3'b000,2'b10,2'b00,3'b001,2'b00,0);
        e_jal      = mk(1,0,0,0,0,3'b000,2'b01,2'b10,3'b000,2'b00,0);
        e_jalr_adr = mk(0,0,0,0,0,3'b000,2'b10,2'b01,3'b000,2'b00,0);
        e_jalr_jmp = mk(1,0,0,0,0,3'b000,2'b01,2'b10,3'b000,2'b00,0);
        e_lui      = mk(0,0,0,0,1,3'b011,2'b00,2'b00,3'b000,2'b11,0);
        e_halt     = mk(0,0,0,0,0,3'b000,2'b00,2'b00,3'b000,2'b00,1);

        rst = 1'b1;
        set_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
        #12;
        check("reset_hold", w_obs, e_zero);
        @(posedge clk);
        #1;
        check("reset_hold_edge", w_obs, e_zero);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // add then sub
        cyc("add_fetch", e_fetch);
        cyc("add_decode", e_decode);
        cyc("add_exec", e_add);
        cyc("add_wb", e_alu_wb);
        set_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
        cyc("sub_fetch", e_fetch);
        cyc("sub_decode", e_decode);
        cyc("sub_exec", e_sub);
        cyc("sub_wb", e_alu_wb);

        // xori
        set_instr(7'b0010011, 3'b100, 7'b0100000, 1'b0, 1'b0);
        cyc("xori_fetch", e_fetch);
        cyc("xori_decode", e_decode);
        cyc("xori_exec", e_xori);
        cyc("xori_wb", e_alu_wb);

        // lw then sw
        set_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
        cyc("lw_fetch", e_fetch);
        cyc("lw_decode", e_decode);
        cyc("lw_adr", e_adr_ld);
        cyc("lw_rd", e_mem_rd);
        cyc("lw_wb", e_mem_wb);
        set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0);
        cyc("sw_fetch", e_fetch);
        cyc("sw_decode", e_decode);
        cyc("sw_adr", e_adr_st);
        cyc("sw_wr", e_mem_wr);

        // branches
        set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0);
        cyc("beq_t_fetch", e_fetch);
        cyc("beq_t_decode", e_decode);
        cyc("beq_t_branch", e_br_t);
        set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0, 1'b1);
        cyc("beq_n_fetch", e_fetch);
        cyc("beq_n_decode", e_decode);
        cyc("beq_n_branch", e_br_n);
        set_instr(7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b1);
        cyc("blt_t_fetch", e_fetch);
        cyc("blt_t_decode", e_decode);
        cyc("blt_t_branch", e_br_t);
        set_instr(7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1);
        cyc("bge_n_fetch", e_fetch);
        cyc("bge_n_decode", e_decode);
        cyc("bge_n_branch", e_br_n);
        set_instr(7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0);
        cyc("bne_t_fetch", e_fetch);
        cyc("bne_t_decode", e_decode);
        cyc("bne_t_branch", e_br_t);

        // jal then jalr
        set_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("jal_fetch", e_fetch);
        cyc("jal_decode", e_decode);
        cyc("jal_jump", e_jal);
        cyc("jal_wb", e_alu_wb);
        set_instr(7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("jalr_fetch", e_fetch);
        cyc("jalr_decode", e_decode);
        cyc("jalr_adr", e_jalr_adr);
        cyc("jalr_jmp", e_jalr_jmp);
        cyc("jalr_wb", e_alu_wb);

        // lui
        set_instr(7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("lui_fetch", e_fetch);
        cyc("lui_decode", e_decode);
        cyc("lui_wb", e_lui);

        // illegal opcode halts until reset
        set_instr(7'b1111111, 3'b000, 7'b0000000, 1'b1, 1'b1);
        cyc("ill_fetch", e_fetch);
        cyc("ill_decode", e_decode);
        for (int i = 0; i < 20; i++) begin
            cyc("ill_halt", e_halt);
        end
        do_reset();

        // illegal R-type func3 (shift) halts
        set_instr(7'b0110011, 3'b001, 7'b0000000, 1'b0, 1'b0);
        cyc("sll_fetch", e_fetch);
        cyc("sll_decode", e_decode);
        cyc("sll_halt", e_halt);
        cyc("sll_halt2", e_halt);
        do_reset();

        // illegal branch func3 halts
        set_instr(7'b1100011, 3'b010, 7'b0000000, 1'b1, 1'b0);
        cyc("brill_fetch", e_fetch);
        cyc("brill_decode", e_decode);
        cyc("brill_halt", e_halt);
        do_reset();

        // reset in the middle of a store
        set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0);
        cyc("rsw_fetch", e_fetch);
        cyc("rsw_decode", e_decode);
        cyc("rsw_adr", e_adr_st);
        check("rsw_wr", w_obs, e_mem_wr);
        do_reset();
        cyc("rsw_refetch", e_fetch);
        cyc("rsw_redecode", e_decode);
        cyc("rsw_readr", e_adr_st);
        cyc("rsw_rewr", e_mem_wr);
        cyc("rsw_after", e_fetch);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
